// File: rtl/mem_pkg.sv
// Shared types and default geometry for the mem_array block.
package mem_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

endpackage

// File: rtl/mem_parity.sv
// Per-byte even-parity generation for the write path and mismatch detection for the read path.
module mem_parity #(
  parameter int NB = 4
) (
  input  logic [NB-1:0][7:0] wr_data,
  input  logic [NB-1:0][7:0] rd_data,
  input  logic [NB-1:0]      rd_par,
  output logic [NB-1:0]      wr_par,
  output logic               rd_mismatch
);

  logic [NB-1:0] rd_calc;

  for (genvar i = 0; i < NB; i++) begin : g_lane
    // Stored bit makes data+parity carry an even number of ones.
    assign wr_par[i]  = ^wr_data[i];
    assign rd_calc[i] = ^rd_data[i];
  end

  assign rd_mismatch = |(rd_calc ^ rd_par);

endmodule

// File: rtl/mem_array.sv
// Byte-enable single-port memory with power-on zeroing sweep and collision flagging.
// Optional per-byte parity storage/check when MEM_PARITY_EN is defined.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [DATA_W/8-1:0]    be,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   rvalid,
  output logic                   busy,
  output logic                   err,
  output logic                   parity_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef logic [NB-1:0][7:0] word_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      INIT: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == {ADDR_W{1'b1}}) state_d = IDLE;
      end
      IDLE: ;
      default: state_d = INIT;
    endcase
  end

  assign busy = (state_q == INIT);

  logic wr_req, rd_fire, coll;
  assign wr_req  = !busy && wr_en && !rd_en;
  assign rd_fire = !busy && rd_en && !wr_en;
  assign coll    = !busy && wr_en && rd_en;

  // Single write port shared by the zeroing sweep and user writes.
  logic [NB-1:0]     mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  word_t             mem_wdata;

  always_comb begin
    mem_we    = '0;
    mem_waddr = addr;
    mem_wdata = wdata;
    if (busy) begin
      mem_we    = '1;
      mem_waddr = ptr_q;
      mem_wdata = '0;
    end else if (wr_req) begin
      mem_we    = be;
    end
  end

  // Storage is intentionally not reset; only the sweep clears it.
  word_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (mem_we[i]) mem_q[mem_waddr][i] <= mem_wdata[i];
  end

  word_t rd_word;
  assign rd_word = mem_q[addr];

  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q, err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (rd_fire) rdata_q <= rd_word;
      rvalid_q <= rd_fire;
      err_q    <= coll;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] wr_par;
  logic          rd_mismatch;
  logic          parity_err_q;

  mem_parity #(.NB(NB)) u_parity (
    .wr_data     (mem_wdata),
    .rd_data     (rd_word),
    .rd_par      (par_q[addr]),
    .wr_par      (wr_par),
    .rd_mismatch (rd_mismatch)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++)
      if (mem_we[i]) par_q[mem_waddr][i] <= wr_par[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_err_q <= 1'b0;
    else        parity_err_q <= rd_fire && rd_mismatch;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_array.sv
// Scoreboard bench for mem_array: reads push expected words, a negedge monitor pops on rvalid.
module tb_mem_array;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int NB     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic              wr_en = 1'b0;
  logic              rd_en = 1'b0;
  logic [NB-1:0]     be = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic [DATA_W-1:0] rdata;
  logic              rvalid, busy, err, parity_err;

  mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
    .be(be), .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .busy(busy),
    .err(err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic coll_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected err: one cycle after any sampled collision outside the sweep.
  always @(posedge clk or negedge reset)
    if (!reset) coll_q <= 1'b0;
    else        coll_q <= wr_en && rd_en && !busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    check("err_timing", {31'd0, err}, {31'd0, coll_q});
    check("parity_err", {31'd0, parity_err}, 32'd0);
    if (rvalid) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rdata", rdata, e.data);
        check("rvalid_latency", cyc, e.cyc);
      end
    end
  end

  task automatic drive(input logic w, input logic r, input logic [ADDR_W-1:0] a,
                       input logic [NB-1:0] b, input logic [DATA_W-1:0] d);
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; be = b; wdata = d;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    drive(1'b0, 1'b1, a, '0, '0);
    sb.push_back('{exp, cyc + 1});
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [NB-1:0] b, input logic [DATA_W-1:0] d);
    drive(1'b1, 1'b0, a, b, d);
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Counts rising edges until busy drops; optionally hammers requests meanwhile.
  task automatic count_busy(output int n, input logic poke);
    n = 0;
    do begin
      if (poke) begin
        wr_en = (n % 3) != 0;
        rd_en = (n % 3) != 2;
        addr  = '0;
        be    = '1;
        wdata = 32'h12345678;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (busy && n < 100);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    int n;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",   {31'd0, busy},   32'd1);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_err",    {31'd0, err},    32'd0);
    check("rst_rdata",  rdata,           32'd0);

    reset = 1'b1;
    count_busy(n, 1'b0);
    check("init_len", n, 32'd16);

    for (int i = 0; i < 16; i++) rd(i[ADDR_W-1:0], 32'h0);
    nop();

    wr(4'd3, 4'b1111, 32'hDEADBEEF);
    rd(4'd3, 32'hDEADBEEF);
    wr(4'd3, 4'b0101, 32'h11223344);
    rd(4'd3, 32'hDE22BE44);
    wr(4'd3, 4'b0000, 32'h00000000);
    rd(4'd3, 32'hDE22BE44);

    drive(1'b1, 1'b1, 4'd5, 4'b1111, 32'hFFFFFFFF);
    nop();
    check("coll_err",    {31'd0, err},    32'd1);
    check("coll_rvalid", {31'd0, rvalid}, 32'd0);
    rd(4'd5, 32'h0);

    wr(4'd15, 4'b1111, 32'hFFFFFFFF);
    wr(4'd0,  4'b1111, 32'hA5A5A5A5);
    rd(4'd15, 32'hFFFFFFFF);
    rd(4'd0,  32'hA5A5A5A5);
    rd(4'd3,  32'hDE22BE44);
    nop();
    nop();

    // Reset mid-sweep must restart the full sweep.
    reset = 1'b0;
    #1;
    check("rst2_rdata", rdata, 32'd0);
    check("rst2_busy",  {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("init8_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    count_busy(n, 1'b1);
    check("restart_len", n, 32'd16);

    rd(4'd0,  32'h0);
    rd(4'd15, 32'h0);
    rd(4'd3,  32'h0);
    nop();
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_array.md
MEM_ARRAY -- requirements
Module: mem_array

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, word width; multiple of 8; NB = DATA_W/8 byte lanes.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port addr  input  ADDR_W  word address for read or write.
REQ-006 SHALL have port wr_en  input  1  write request.
REQ-007 SHALL have port rd_en  input  1  read request.
REQ-008 SHALL have port be  input  NB  byte enables for writes; bit i selects wdata[8i+7:8i].
REQ-009 SHALL have port wdata  input  DATA_W  write data.
REQ-010 SHALL have port rdata  output  DATA_W  registered read data.
REQ-011 SHALL have port rvalid  output  1  one-cycle pulse marking rdata valid.
REQ-012 SHALL have port busy  output  1  high while the init sweep runs; requests ignored.
REQ-013 SHALL have port err  output  1  one-cycle pulse flagging a rd_en/wr_en collision.
REQ-014 SHALL have port parity_err  output  1  one-cycle pulse with rvalid on a parity mismatch.

Function
REQ-015 SHALL implement a two-state FSM: INIT, IDLE.
REQ-016 INIT SHALL write 0 to one word per cycle, addr 0 to DEPTH-1, with busy=1; after DEPTH cycles it SHALL go to IDLE with busy=0.
REQ-017 In INIT, wr_en/rd_en SHALL be ignored: no memory change, no rvalid, no err.
REQ-018 In IDLE, wr_en=1 & rd_en=0 SHALL update only the bytes of mem[addr] whose be bit is set, at that edge.
REQ-019 A write with be=0 SHALL change nothing and raise no error.
REQ-020 In IDLE, rd_en=1 & wr_en=0 SHALL load rdata with mem[addr] and set rvalid=1 for exactly one cycle following that edge (latency 1).
REQ-021 rdata SHALL hold its last value when rvalid=0.
REQ-022 In IDLE, wr_en=1 & rd_en=1 SHALL perform neither operation and SHALL pulse err for one cycle after that edge.
REQ-023 A read in the cycle after a write to the same addr SHALL return the newly written data.
REQ-024 Every addr value SHALL be valid; no out-of-range case exists.
REQ-025 Back-to-back reads SHALL give one rvalid pulse per read, with no bubble.

Reset
REQ-026 reset=0 SHALL immediately force state=INIT, init pointer=0, busy=1, rdata=0, rvalid=0, err=0, parity_err=0.
REQ-027 Memory contents SHALL NOT be reset asynchronously; they SHALL be cleared only by the INIT sweep.
REQ-028 reset asserted during INIT or IDLE SHALL restart the full DEPTH-cycle sweep after release.

Configuration
REQ-029 With MEM_PARITY_EN defined, the block SHALL store one even-parity bit per byte lane, update it with its byte, clear it in INIT, and check it on each read.
REQ-030 With MEM_PARITY_EN defined, a read with any lane mismatch SHALL pulse parity_err together with rvalid; rdata SHALL still return the stored data.
REQ-031 Without MEM_PARITY_EN, the block SHALL store no parity bits and SHALL tie parity_err to 0.

Structure
REQ-032 Package mem_pkg SHALL hold the FSM state enum (INIT, IDLE) and the default ADDR_W/DATA_W constants.
REQ-033 Parity generation and checking SHALL be a sub-module, mem_parity (byte-lane parity vector in, parity out), instantiated only under MEM_PARITY_EN.

Verification
REQ-034 Release reset, then read every address -> busy=1 for exactly 16 cycles (ADDR_W=4), then every read gives rdata=0 with rvalid=1, err=0 and parity_err=0.
REQ-035 Write 0xDEADBEEF to addr 3 with be=4'b1111, then read addr 3 -> rdata=0xDEADBEEF and rvalid=1 one cycle after the read edge.
REQ-036 Write 0x11223344 to addr 3 with be=4'b0101, then read addr 3 -> rdata=0xDE22BE44.
REQ-037 Drive wr_en=rd_en=1 at addr 5 with wdata=0xFFFFFFFF -> err=1 for one cycle, rvalid=0, and a later read of addr 5 gives 0.
REQ-038 Assert reset at INIT cycle 8, then release -> busy stays high for 16 full cycles after release; rd_en during busy gives no rvalid.
REQ-039 A bench assertion SHALL check that err rises exactly one cycle after every sampled wr_en&rd_en in IDLE and at no other time.
